// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg
//   Shared definitions for the multi-cycle RISC-V main control unit:
//   opcode constants, FSM state encoding, datapath select codes,
//   the one-hot instruction class carried in opReg and the strobe bundle.
package riscv_ctrl_pkg;

   // Opcodes recognised by the controller
   localparam logic [6:0] OPC_R   = 7'b0110011;
   localparam logic [6:0] OPC_LD  = 7'b0000011;
   localparam logic [6:0] OPC_SD  = 7'b0100011;
   localparam logic [6:0] OPC_BEQ = 7'b1100011;
   localparam logic [6:0] OPC_IMM = 7'b0010011;
   localparam logic [6:0] OPC_JAL = 7'b1101111;

   // Debug-visible state encoding (5 and 6 unused)
   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_FAULT  = 3'd7
   } state_t;

   // aluOp codes
   localparam logic [1:0] ALUOP_ADD = 2'b00;
   localparam logic [1:0] ALUOP_SUB = 2'b01;
   localparam logic [1:0] ALUOP_RFN = 2'b10;
   localparam logic [1:0] ALUOP_IFN = 2'b11;

   // aluSrcB codes
   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_FOUR = 2'b01;
   localparam logic [1:0] SRCB_IMM  = 2'b10;

   // memToReg codes
   localparam logic [1:0] WB_ALUOUT = 2'b00;
   localparam logic [1:0] WB_MDR    = 2'b01;
   localparam logic [1:0] WB_PC     = 2'b10;

   // One-hot instruction class latched in DECODE
   typedef struct packed {
      logic r;
      logic imm;
      logic ld;
      logic sd;
      logic beq;
      logic jal;
   } instr_class_t;

   // Datapath strobes and selects produced each cycle
   typedef struct packed {
      logic       pcWrite;
      logic       pcWriteCond;
      logic       pcSource;
      logic       irWrite;
      logic       iOrD;
      logic       memRead;
      logic       memWrite;
      logic [1:0] memToReg;
      logic       aluSrcA;
      logic [1:0] aluSrcB;
      logic [1:0] aluOp;
      logic       regWrite;
      logic       instrDone;
   } ctrl_t;

   // States in which the controller waits on memReady
   function automatic logic is_mem_state(input state_t s);
      return (s == ST_FETCH) || (s == ST_MEM);
   endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if
//   Bundle between the main control unit and the datapath/memory side.
//   slave  : controller view (opcode, memReady in; strobes, status out)
//   master : datapath view (opcode, memReady out; strobes, status in)
interface multicycle_controller_if;

   logic [6:0] opcode;
   logic       memReady;

   logic       pcWrite;
   logic       pcWriteCond;
   logic       pcSource;
   logic       irWrite;
   logic       iOrD;
   logic       memRead;
   logic       memWrite;
   logic [1:0] memToReg;
   logic       aluSrcA;
   logic [1:0] aluSrcB;
   logic [1:0] aluOp;
   logic       regWrite;
   logic       instrDone;
   logic       fault;
   logic       illegal;
   logic [2:0] state;

   modport slave (
      input  opcode, memReady,
      output pcWrite, pcWriteCond, pcSource, irWrite, iOrD, memRead, memWrite,
             memToReg, aluSrcA, aluSrcB, aluOp, regWrite, instrDone,
             fault, illegal, state
   );

   modport master (
      output opcode, memReady,
      input  pcWrite, pcWriteCond, pcSource, irWrite, iOrD, memRead, memWrite,
             memToReg, aluSrcA, aluSrcB, aluOp, regWrite, instrDone,
             fault, illegal, state
   );

endinterface

// File: rtl/opcode_decode.sv
// opcode_decode
//   Combinational opcode classifier.
//   i_opcode : 7-bit opcode from IR
//   o_class  : one-hot instruction class (all zero when illegal)
//   o_legal  : opcode is supported in this configuration
//   EN_IMM_OPS = 0 makes OP-IMM and JAL illegal.
module opcode_decode
   import riscv_ctrl_pkg::*;
#(
   parameter bit EN_IMM_OPS = 1'b1
) (
   input  logic [6:0]   i_opcode,
   output instr_class_t o_class,
   output logic         o_legal
);

   always_comb begin
      o_class = '0;
      case (i_opcode)
         OPC_R:   o_class.r   = 1'b1;
         OPC_LD:  o_class.ld  = 1'b1;
         OPC_SD:  o_class.sd  = 1'b1;
         OPC_BEQ: o_class.beq = 1'b1;
         OPC_IMM: o_class.imm = EN_IMM_OPS;
         OPC_JAL: o_class.jal = EN_IMM_OPS;
         default: o_class     = '0;
      endcase
      o_legal = |o_class;
   end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller
//   Multi-cycle main control unit: FETCH -> DECODE -> EXEC -> [MEM] -> [WB].
//   clk   : rising-edge clock
//   reset : synchronous, active-high; forces every output to 0 while high
//   bus   : multicycle_controller_if.slave (opcode/memReady in, strobes,
//           instrDone, fault, illegal, state out)
//   MEM_TIMEOUT : cycles memReady may stay low in FETCH/MEM (0 = no limit)
//   EN_IMM_OPS  : enables OP-IMM and JAL
//   CNT_W       : timeout counter width (2^CNT_W > MEM_TIMEOUT)
module multicycle_controller
   import riscv_ctrl_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter bit          EN_IMM_OPS  = 1'b1,
   parameter int unsigned CNT_W       = 8
) (
   input logic                     clk,
   input logic                     reset,
   multicycle_controller_if.slave  bus
);

   localparam bit               TO_EN = (MEM_TIMEOUT != 0);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MEM_TIMEOUT - 1);

   state_t           r_state;
   state_t           w_next;
   instr_class_t     r_opReg;
   logic [CNT_W-1:0] r_cnt;
   logic             r_fault;
   logic             r_illegal;

   instr_class_t     w_dec_class;
   logic             w_dec_legal;
   logic             w_waiting;
   logic             w_timeout;
   ctrl_t            w_ctrl;
   ctrl_t            w_out;
   logic [2:0]       w_state_out;

   opcode_decode #(
      .EN_IMM_OPS(EN_IMM_OPS)
   ) u_opcode_decode (
      .i_opcode(bus.opcode),
      .o_class (w_dec_class),
      .o_legal (w_dec_legal)
   );

   // A ready in the limit cycle is not a wait, so it never times out.
   assign w_waiting = is_mem_state(r_state) && !bus.memReady;
   assign w_timeout = TO_EN && w_waiting && (r_cnt == LIMIT);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= ST_FETCH;
         r_opReg   <= '0;
         r_cnt     <= '0;
         r_fault   <= 1'b0;
         r_illegal <= 1'b0;
      end else begin
         r_state <= w_next;
         if (r_state == ST_DECODE)
            r_opReg <= w_dec_class;
         if (w_next != r_state)
            r_cnt <= '0;
         else if (w_waiting)
            r_cnt <= r_cnt + CNT_W'(1);
         if (w_next == ST_FAULT)
            r_fault <= 1'b1;
         if ((r_state == ST_DECODE) && !w_dec_legal)
            r_illegal <= 1'b1;
      end
   end

   always_comb begin
      w_next = r_state;
      w_ctrl = '0;
      case (r_state)
         ST_FETCH: begin
            w_ctrl.memRead = 1'b1;
            if (bus.memReady) begin
               w_ctrl.irWrite = 1'b1;
               w_ctrl.pcWrite = 1'b1;
               w_ctrl.aluSrcB = SRCB_FOUR;
               w_ctrl.aluOp   = ALUOP_ADD;
               w_next         = ST_DECODE;
            end else if (w_timeout) begin
               w_next = ST_FAULT;
            end
         end
         ST_DECODE: begin
            w_ctrl.aluSrcB = SRCB_IMM;
            w_ctrl.aluOp   = ALUOP_ADD;
            w_next         = w_dec_legal ? ST_EXEC : ST_FAULT;
         end
         ST_EXEC: begin
            if (r_opReg.r) begin
               w_ctrl.aluSrcA = 1'b1;
               w_ctrl.aluSrcB = SRCB_RS2;
               w_ctrl.aluOp   = ALUOP_RFN;
               w_next         = ST_WB;
            end else if (r_opReg.imm) begin
               w_ctrl.aluSrcA = 1'b1;
               w_ctrl.aluSrcB = SRCB_IMM;
               w_ctrl.aluOp   = ALUOP_IFN;
               w_next         = ST_WB;
            end else if (r_opReg.ld || r_opReg.sd) begin
               w_ctrl.aluSrcA = 1'b1;
               w_ctrl.aluSrcB = SRCB_IMM;
               w_ctrl.aluOp   = ALUOP_ADD;
               w_next         = ST_MEM;
            end else if (r_opReg.beq) begin
               w_ctrl.aluSrcA     = 1'b1;
               w_ctrl.aluSrcB     = SRCB_RS2;
               w_ctrl.aluOp       = ALUOP_SUB;
               w_ctrl.pcWriteCond = 1'b1;
               w_ctrl.pcSource    = 1'b1;
               w_ctrl.instrDone   = 1'b1;
               w_next             = ST_FETCH;
            end else if (r_opReg.jal) begin
               // PC already holds PC+4 from FETCH; ALUOut holds the target.
               w_ctrl.regWrite  = 1'b1;
               w_ctrl.memToReg  = WB_PC;
               w_ctrl.pcWrite   = 1'b1;
               w_ctrl.pcSource  = 1'b1;
               w_ctrl.instrDone = 1'b1;
               w_next           = ST_FETCH;
            end else begin
               w_next = ST_FAULT;
            end
         end
         ST_MEM: begin
            w_ctrl.iOrD     = 1'b1;
            w_ctrl.memRead  = r_opReg.ld;
            w_ctrl.memWrite = r_opReg.sd;
            if (bus.memReady) begin
               if (r_opReg.ld) begin
                  w_next = ST_WB;
               end else begin
                  w_ctrl.instrDone = 1'b1;
                  w_next           = ST_FETCH;
               end
            end else if (w_timeout) begin
               w_next = ST_FAULT;
            end
         end
         ST_WB: begin
            w_ctrl.regWrite  = 1'b1;
            w_ctrl.memToReg  = r_opReg.ld ? WB_MDR : WB_ALUOUT;
            w_ctrl.instrDone = 1'b1;
            w_next           = ST_FETCH;
         end
         ST_FAULT: begin
            w_next = ST_FAULT;
         end
         default: begin
            w_next = ST_FAULT;
         end
      endcase
   end

   // Outputs are forced low during reset so an interrupted instruction
   // never shows a completing strobe or instrDone.
   always_comb begin
      w_out       = w_ctrl;
      w_state_out = r_state;
      if (reset) begin
         w_out       = '0;
         w_state_out = '0;
      end
   end

   assign bus.pcWrite     = w_out.pcWrite;
   assign bus.pcWriteCond = w_out.pcWriteCond;
   assign bus.pcSource    = w_out.pcSource;
   assign bus.irWrite     = w_out.irWrite;
   assign bus.iOrD        = w_out.iOrD;
   assign bus.memRead     = w_out.memRead;
   assign bus.memWrite    = w_out.memWrite;
   assign bus.memToReg    = w_out.memToReg;
   assign bus.aluSrcA     = w_out.aluSrcA;
   assign bus.aluSrcB     = w_out.aluSrcB;
   assign bus.aluOp       = w_out.aluOp;
   assign bus.regWrite    = w_out.regWrite;
   assign bus.instrDone   = w_out.instrDone;
   assign bus.fault       = r_fault   && !reset;
   assign bus.illegal     = r_illegal && !reset;
   assign bus.state       = w_state_out;

endmodule
